// File: rtl/sign_mag_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor for aligned mantissas in the FPU add path.
// Stage 1 resolves the effective operation and orders operands; stage 2 produces |res|, sign and zero.
module sign_mag_addsub_pipe #(
    parameter int MAN_W = 24,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [MAN_W-1:0] a,
    input  logic [MAN_W-1:0] b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W:0]   res,
    output logic             sign_res,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out
);

    // Handshake: a beat moves across an interface on a rising edge where valid && ready;
    // valid never waits on ready, and in_ready depends only on pipeline state and out_ready.
    logic             stage1_load;
    logic             stage2_load;
    logic             out_fire;

    logic             s1_valid_q, s1_valid_d;
    logic [MAN_W-1:0] big_q, big_d;
    logic [MAN_W-1:0] small_q, small_d;
    logic             sign_big_q, sign_big_d;
    logic             eff_sub_q, eff_sub_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    logic             out_valid_q, out_valid_d;
    logic [MAN_W:0]   res_q, res_d;
    logic             sign_res_q, sign_res_d;
    logic             zero_q, zero_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;

    logic             sb_eff;
    logic             swap;

    assign out_fire    = out_valid_q && out_ready;
    assign stage2_load = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready    = !s1_valid_q || !out_valid_q || out_ready;
    assign stage1_load = in_valid && in_ready;

    // Only an effective subtract needs ordering; ties keep a so the sign follows a.
    always_comb begin
        sb_eff     = sign_b ^ op_sub;
        eff_sub_d  = sign_a ^ sb_eff;
        swap       = eff_sub_d && (a < b);
        big_d      = swap ? b : a;
        small_d    = swap ? a : b;
        sign_big_d = swap ? sb_eff : sign_a;
        tag1_d     = tag_in;
    end

    // Exact cancellation yields +0; a same-sign zero sum keeps the operands' sign.
    always_comb begin
        if (eff_sub_q) begin
            res_d = {1'b0, big_q} - {1'b0, small_q};
        end else begin
            res_d = {1'b0, big_q} + {1'b0, small_q};
        end
        zero_d     = (res_d == '0);
        sign_res_d = sign_big_q && !(eff_sub_q && zero_d);
        tag_out_d  = tag1_q;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (stage1_load) begin
            s1_valid_d = 1'b1;
        end else if (stage2_load) begin
            s1_valid_d = 1'b0;
        end
        if (stage2_load) begin
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            big_q       <= '0;
            small_q     <= '0;
            sign_big_q  <= 1'b0;
            eff_sub_q   <= 1'b0;
            tag1_q      <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            sign_res_q  <= 1'b0;
            zero_q      <= 1'b0;
            tag_out_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (stage1_load) begin
                big_q      <= big_d;
                small_q    <= small_d;
                sign_big_q <= sign_big_d;
                eff_sub_q  <= eff_sub_d;
                tag1_q     <= tag1_d;
            end
            if (stage2_load) begin
                res_q      <= res_d;
                sign_res_q <= sign_res_d;
                zero_q     <= zero_d;
                tag_out_q  <= tag_out_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign sign_res  = sign_res_q;
    assign zero      = zero_q;
    assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_sign_mag_addsub_pipe.sv
// Scoreboard bench for sign_mag_addsub_pipe: driver pushes model results, monitor pops on output transfers.
module tb_sign_mag_addsub_pipe;

    localparam int MAN_W = 24;
    localparam int TAG_W = 4;
    localparam int EW    = MAN_W + TAG_W + 3;
    localparam logic [MAN_W-1:0] MAG_MAX = {MAN_W{1'b1}};

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic             sign_a;
    logic             sign_b;
    logic [MAN_W-1:0] a;
    logic [MAN_W-1:0] b;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [MAN_W:0]   res;
    logic             sign_res;
    logic             zero;
    logic [TAG_W-1:0] tag_out;

    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    int            checks    = 0;
    int            errors    = 0;
    int            cyc       = 0;
    int            rdy_mode  = 0;
    bit            lat_chk   = 1'b0;

    sign_mag_addsub_pipe #(.MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .a         (a),
        .b         (b),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .sign_res  (sign_res),
        .zero      (zero),
        .tag_out   (tag_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Signed-integer view: value = (-1)^sign * magnitude, result = |sum| with zero-sign rules.
    function automatic logic [EW-1:0] model(input logic op, input logic sa, input logic sb,
                                            input logic [MAN_W-1:0] va, input logic [MAN_W-1:0] vb,
                                            input logic [TAG_W-1:0] t);
        longint x, y, s, m;
        logic   neg_b, sg;
        neg_b = sb ^ op;
        x = sa ? -longint'(va) : longint'(va);
        y = neg_b ? -longint'(vb) : longint'(vb);
        s = x + y;
        m = (s < 0) ? -s : s;
        sg = (s < 0);
        if (s == 0) sg = sa & neg_b;
        return {sg, (s == 0), t, m[MAN_W:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
    task automatic randomize_inputs();
        op_sub = 1'($urandom_range(0, 1));
        sign_a = 1'($urandom_range(0, 1));
        sign_b = 1'($urandom_range(0, 1));
        a      = MAN_W'($urandom_range(0, int'(MAG_MAX)));
        b      = MAN_W'($urandom_range(0, int'(MAG_MAX)));
        tag_in = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
    endtask

    task automatic send(input logic op, input logic sa, input logic sb,
                        input logic [MAN_W-1:0] va, input logic [MAN_W-1:0] vb,
                        input logic [TAG_W-1:0] t);
        int waits;
        bit done;
        waits = 0;
        done  = 1'b0;
        op_sub = op; sign_a = sa; sign_b = sb; a = va; b = vb; tag_in = t;
        in_valid = 1'b1;
        while (!done) begin
            #2;
            // in_ready may drop only when two beats are held and the consumer stalls.
            check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
            if (in_ready) begin
                exp_q.push_back(model(op, sa, sb, va, vb, t));
                lat_q.push_back(cyc);
                done = 1'b1;
            end else if (++waits > 100) begin
                checks++; errors++;
                $display("FAIL send_timeout: got in_ready=0 expected in_ready=1");
                done = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_rand(input logic [TAG_W-1:0] t);
        logic [MAN_W-1:0] va, vb;
        int sel;
        sel = $urandom_range(0, 7);
        va  = MAN_W'($urandom_range(0, int'(MAG_MAX)));
        vb  = MAN_W'($urandom_range(0, int'(MAG_MAX)));
        if (sel == 0) vb = va;
        if (sel == 1) begin va = '0; vb = '0; end
        send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), va, vb, t);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        randomize_inputs();
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] prev, got, e;
        bit            stall_prev;
        int            issued;
        stall_prev = 1'b0;
        prev       = '0;
        out_ready  = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            #1;
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            got = {sign_res, zero, tag_out, res};
            if (stall_prev) check("stall_hold", 64'(got), 64'(prev));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got 0x%0h expected no beat", got);
                end else begin
                    e      = exp_q.pop_front();
                    issued = lat_q.pop_front();
                    check("result", 64'(got), 64'(e));
                    if (lat_chk) check("latency", 64'(cyc - issued), 64'd2);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev       = got;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        randomize_inputs();
        repeat (3) begin
            @(negedge clk);
            randomize_inputs();
            in_valid = 1'($urandom_range(0, 1));
        end
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        check("rst_sign_res", 64'(sign_res), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_tag_out", 64'(tag_out), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed corner cases, isolated beats, consumer always ready.
        lat_chk  = 1'b1;
        rdy_mode = 0;
        send(1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'h000001, 4'd1); idle(3);
        send(1'b1, 1'b0, 1'b0, 24'h000010, 24'h000030, 4'd2); idle(3);
        send(1'b0, 1'b1, 1'b0, 24'h400000, 24'h100000, 4'd3); idle(3);
        send(1'b1, 1'b1, 1'b1, 24'h123456, 24'h123456, 4'd4); idle(3);
        send(1'b0, 1'b1, 1'b1, 24'h000000, 24'h000000, 4'd5); idle(3);
        send(1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000, 4'd6); idle(3);
        drain();

        // Full-rate streaming: fixed 2-cycle latency per back-to-back beat means one result per cycle.
        for (int i = 0; i < 16; i++) send_rand(TAG_W'(i));
        drain();
        lat_chk = 1'b0;

        // Backpressure: eight tagged beats against a randomly stalling consumer.
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send_rand(TAG_W'(i));
        drain();

        // Longer random traffic with gaps.
        for (int i = 0; i < 60; i++) begin
            send_rand(TAG_W'(i));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Reset while both stages are full and the consumer is stalled.
        rdy_mode = 2;
        send(1'b0, 1'b0, 1'b0, 24'h000005, 24'h000003, 4'd9);
        send(1'b0, 1'b0, 1'b0, 24'h000007, 24'h000007, 4'd10);
        idle(2);
        #1;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        check("pre_reset_res", 64'(res), 64'h8);
        check("pre_reset_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_res", 64'(res), 64'd0);
        check("midrst_tag_out", 64'(tag_out), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 0;
        lat_chk  = 1'b1;
        @(negedge clk);
        send(1'b0, 1'b1, 1'b0, 24'h000001, 24'h000002, 4'd11);
        drain();
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
